// File: rtl/jump_redirect_ctrl_if.sv
// rtl/jump_redirect_ctrl_if.sv - decode request, fetch redirect and R7 link handshakes for jump_redirect_ctrl
interface jump_redirect_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  opcode;
  logic [10:0] instr_imm;
  logic [15:0] rs_val;
  logic [15:0] pc_plus2;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        redirect_ack;
  logic        flush;
  logic        link_wr_en;
  logic [15:0] link_wr_data;
  logic        link_wr_ack;
  logic        busy;

  modport master (
    input  req_valid, opcode, instr_imm, rs_val, pc_plus2, redirect_ack, link_wr_ack,
    output req_ready, redirect_valid, redirect_pc, flush, link_wr_en, link_wr_data, busy
  );

  modport slave (
    output req_valid, opcode, instr_imm, rs_val, pc_plus2, redirect_ack, link_wr_ack,
    input  req_ready, redirect_valid, redirect_pc, flush, link_wr_en, link_wr_data, busy
  );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// rtl/jump_redirect_ctrl.sv - J/JR/JAL/JALR target compute, fetch redirect, timed flush and R7 link write
// Optional feature: JUMP_LINK_EN enables the LINK state for JAL/JALR.
module jump_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  jump_redirect_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_LINK     = 2'd3;

  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);
  // The counter is loaded with one less so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD = HAS_FLUSH ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] target_q;

  logic        is_jump;
  logic        is_reg;
  logic        accept;
  logic [15:0] base;
  logic [15:0] offset;
  logic [15:0] target;
  logic        link_pending;
  logic        link_ack;

  always_comb begin
    is_jump = (bus.opcode[4:2] == 3'b001);
    is_reg  = bus.opcode[0];
    base    = is_reg ? bus.rs_val : bus.pc_plus2;
    offset  = is_reg ? {{8{bus.instr_imm[7]}}, bus.instr_imm[7:0]}
                     : {{5{bus.instr_imm[10]}}, bus.instr_imm};
    target  = base + offset;
    // Non-jump opcodes are consumed from decode but never leave IDLE.
    accept  = bus.req_valid && (state_q == S_IDLE) && is_jump;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.redirect_ack) begin
          if (HAS_FLUSH) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else if (link_pending) begin
            state_d = S_LINK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = link_pending ? S_LINK : S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_LINK: begin
        if (link_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      target_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) target_q <= target;
    end
  end

`ifdef JUMP_LINK_EN
  logic        link_q;
  logic [15:0] link_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q      <= 1'b0;
      link_data_q <= 16'd0;
    end else if (accept) begin
      link_q      <= bus.opcode[1];
      link_data_q <= bus.pc_plus2;
    end
  end

  assign link_pending     = link_q;
  assign link_ack         = bus.link_wr_ack;
  assign bus.link_wr_en   = (state_q == S_LINK);
  assign bus.link_wr_data = (state_q == S_LINK) ? link_data_q : 16'd0;
`else
  logic unused_link;
  // JAL/JALR collapse onto J/JR, so the link bit of the opcode and the writeback ack are dead.
  assign unused_link      = bus.link_wr_ack ^ bus.opcode[1];
  assign link_pending     = 1'b0;
  assign link_ack         = 1'b0;
  assign bus.link_wr_en   = 1'b0;
  assign bus.link_wr_data = 16'd0;
`endif

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.redirect_valid = (state_q == S_REDIRECT);
  assign bus.redirect_pc    = (state_q == S_REDIRECT) ? target_q : 16'd0;
  assign bus.flush          = (state_q == S_REDIRECT) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// tb/tb_jump_redirect_ctrl.sv - randomized and directed checks of jump_redirect_ctrl against a timestamp model
module tb_jump_redirect_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jump_redirect_ctrl_if bus0();
  jump_redirect_ctrl_if bus1();

  jump_redirect_ctrl #(.FLUSH_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  jump_redirect_ctrl #(.FLUSH_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef JUMP_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Model: each jump is described by when it was acked, not by a state machine.
  int          fc[2] = '{2, 0};
  bit          act[2];
  bit          ack_seen[2];
  int          t_rack[2];
  bit          lnk[2];
  bit          lack_seen[2];
  logic [15:0] tgt[2];
  logic [15:0] pcp[2];

  function automatic bit m_redir(int i);
    return act[i] && !ack_seen[i];
  endfunction
  function automatic bit m_flush(int i);
    return act[i] && (!ack_seen[i] || cyc < t_rack[i] + fc[i]);
  endfunction
  function automatic bit m_link(int i);
    return act[i] && ack_seen[i] && (cyc >= t_rack[i] + fc[i]) && lnk[i] && !lack_seen[i];
  endfunction
  function automatic bit m_busy(int i);
    return m_flush(i) || m_link(i);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic compare_inst(input int i, input logic rdy, input logic rv, input logic [15:0] rpc,
                              input logic fl, input logic lwe, input logic [15:0] lwd, input logic bsy);
    chk($sformatf("u%0d.req_ready", i),      16'(rdy), 16'(!m_busy(i)));
    chk($sformatf("u%0d.busy", i),           16'(bsy), 16'(m_busy(i)));
    chk($sformatf("u%0d.redirect_valid", i), 16'(rv),  16'(m_redir(i)));
    chk($sformatf("u%0d.redirect_pc", i),    rpc,      m_redir(i) ? tgt[i] : 16'd0);
    chk($sformatf("u%0d.flush", i),          16'(fl),  16'(m_flush(i)));
    chk($sformatf("u%0d.link_wr_en", i),     16'(lwe), 16'(m_link(i)));
    chk($sformatf("u%0d.link_wr_data", i),   lwd,      m_link(i) ? pcp[i] : 16'd0);
  endtask

  task automatic compare_all();
    compare_inst(0, bus0.req_ready, bus0.redirect_valid, bus0.redirect_pc, bus0.flush,
                 bus0.link_wr_en, bus0.link_wr_data, bus0.busy);
    compare_inst(1, bus1.req_ready, bus1.redirect_valid, bus1.redirect_pc, bus1.flush,
                 bus1.link_wr_en, bus1.link_wr_data, bus1.busy);
  endtask

  task automatic drive(input logic rv, input logic [4:0] op, input logic [10:0] imm,
                       input logic [15:0] rs, input logic [15:0] pc, input logic rack, input logic lack);
    bus0.req_valid = rv;  bus0.opcode = op;  bus0.instr_imm = imm;  bus0.rs_val = rs;
    bus0.pc_plus2 = pc;   bus0.redirect_ack = rack;  bus0.link_wr_ack = lack;
    bus1.req_valid = rv;  bus1.opcode = op;  bus1.instr_imm = imm;  bus1.rs_val = rs;
    bus1.pc_plus2 = pc;   bus1.redirect_ack = rack;  bus1.link_wr_ack = lack;
  endtask

  task automatic model_update(input int i, input logic rv, input logic [4:0] op, input logic [10:0] imm,
                              input logic [15:0] rs, input logic [15:0] pc, input logic rack, input logic lack);
    int off;
    if (!m_busy(i)) begin
      if (rv && op[4:2] == 3'b001) begin
        off          = op[0] ? int'($signed(imm[7:0])) : int'($signed(imm));
        tgt[i]       = 16'((op[0] ? int'(rs) : int'(pc)) + off);
        pcp[i]       = pc;
        lnk[i]       = LINK_EN && op[1];
        act[i]       = 1'b1;
        ack_seen[i]  = 1'b0;
        lack_seen[i] = 1'b0;
      end
    end else if (m_redir(i)) begin
      if (rack) begin
        ack_seen[i] = 1'b1;
        t_rack[i]   = cyc + 1;
      end
    end else if (m_link(i) && lack) begin
      lack_seen[i] = 1'b1;
    end
  endtask

  task automatic step(input logic rv, input logic [4:0] op, input logic [10:0] imm,
                      input logic [15:0] rs, input logic [15:0] pc, input logic rack, input logic lack);
    compare_all();
    drive(rv, op, imm, rs, pc, rack, lack);
    model_update(0, rv, op, imm, rs, pc, rack, lack);
    model_update(1, rv, op, imm, rs, pc, rack, lack);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rack, input logic lack);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, rack, lack);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, OP_J, 11'h001, 16'h0, 16'h1234, 1'b1, 1'b1);
    #1;
    chk("rst u0.req_ready", 16'(bus0.req_ready), 16'd1);
    chk("rst u0.redirect_valid", 16'(bus0.redirect_valid), 16'd0);
    chk("rst u0.redirect_pc", bus0.redirect_pc, 16'd0);
    chk("rst u0.flush", 16'(bus0.flush), 16'd0);
    chk("rst u0.link_wr_en", 16'(bus0.link_wr_en), 16'd0);
    chk("rst u0.link_wr_data", bus0.link_wr_data, 16'd0);
    chk("rst u0.busy", 16'(bus0.busy), 16'd0);
    chk("rst u1.busy", 16'(bus1.busy), 16'd0);
    chk("rst u1.flush", 16'(bus1.flush), 16'd0);
    chk("rst u1.link_wr_en", 16'(bus1.link_wr_en), 16'd0);
    for (int i = 0; i < 2; i++) act[i] = 1'b0;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv, rack, lack;
    logic [4:0] op;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // J: 0x0100 + sext(0x7FE) = 0x00FE, flush spans REDIRECT plus two FLUSH cycles
    step(1'b1, OP_J, 11'h7FE, 16'h0, 16'h0100, 1'b0, 1'b0);
    chk("J model target", tgt[0], 16'h00FE);
    chk("J redirect_pc", bus0.redirect_pc, 16'h00FE);
    chk("J flush c1", 16'(bus0.flush), 16'd1);
    chk("J req_ready c1", 16'(bus0.req_ready), 16'd0);
    step(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    chk("J flush c2", 16'(bus0.flush), 16'd1);
    chk("J redirect_valid c2", 16'(bus0.redirect_valid), 16'd0);
    chk("J F0 flush after ack", 16'(bus1.flush), 16'd0);
    chk("J F0 busy after ack", 16'(bus1.busy), 16'd0);
    idle(1, 1'b0, 1'b0);
    chk("J flush c3", 16'(bus0.flush), 16'd1);
    idle(1, 1'b0, 1'b0);
    chk("J flush c4", 16'(bus0.flush), 16'd0);
    chk("J busy c4", 16'(bus0.busy), 16'd0);

    // JAL: link write held while link_wr_ack stays low two cycles
    step(1'b1, OP_JAL, 11'h010, 16'h0, 16'h0200, 1'b0, 1'b0);
    chk("JAL redirect_pc", bus0.redirect_pc, 16'h0210);
    step(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    chk("JAL link_wr_en c4", 16'(bus0.link_wr_en), 16'(LINK_EN));
    chk("JAL link_wr_data c4", bus0.link_wr_data, LINK_EN ? 16'h0200 : 16'h0000);
    chk("JAL flush in link", 16'(bus0.flush), 16'd0);
    idle(2, 1'b0, 1'b0);
    chk("JAL link_wr_en c6", 16'(bus0.link_wr_en), 16'(LINK_EN));
    idle(1, 1'b0, 1'b1);
    chk("JAL busy c7", 16'(bus0.busy), 16'd0);
    idle(2, 1'b1, 1'b1);

    // JALR wrap and JR with only imm[7:0] used
    step(1'b1, OP_JALR, 11'h020, 16'hFFF0, 16'h4444, 1'b0, 1'b0);
    chk("JALR wrap model", tgt[0], 16'h0010);
    chk("JALR wrap redirect_pc", bus0.redirect_pc, 16'h0010);
    idle(6, 1'b1, 1'b1);
    step(1'b1, OP_JR, 11'h580, 16'h1000, 16'h0, 1'b0, 1'b0);
    chk("JR redirect_pc", bus0.redirect_pc, 16'h0F80);
    idle(6, 1'b1, 1'b1);

    // Redirect stall with a stray link ack
    step(1'b1, OP_J, 11'h004, 16'h0, 16'h3000, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    chk("stall redirect_pc c2", bus0.redirect_pc, 16'h3004);
    idle(2, 1'b0, 1'b0);
    chk("stall redirect_valid c4", 16'(bus0.redirect_valid), 16'd1);
    chk("stall req_ready c4", 16'(bus0.req_ready), 16'd0);
    idle(1, 1'b1, 1'b0);
    chk("stall released", 16'(bus0.redirect_valid), 16'd0);
    idle(4, 1'b1, 1'b1);

    // Non-jump opcode is dropped
    step(1'b1, 5'b00000, 11'h123, 16'h1111, 16'h2222, 1'b1, 1'b1);
    chk("nonjump busy", 16'(bus0.busy), 16'd0);
    chk("nonjump redirect", 16'(bus1.redirect_valid), 16'd0);

    // Back-to-back J: second waits for IDLE
    step(1'b1, OP_J, 11'h000, 16'h0, 16'h4000, 1'b0, 1'b0);
    step(1'b1, OP_J, 11'h002, 16'h0, 16'h5000, 1'b1, 1'b0);
    chk("b2b held off", 16'(bus0.req_ready), 16'd0);
    step(1'b1, OP_J, 11'h002, 16'h0, 16'h5000, 1'b0, 1'b0);
    step(1'b1, OP_J, 11'h002, 16'h0, 16'h5000, 1'b0, 1'b0);
    chk("b2b ready again", 16'(bus0.req_ready), 16'd1);
    step(1'b1, OP_J, 11'h002, 16'h0, 16'h5000, 1'b0, 1'b0);
    chk("b2b second target", bus0.redirect_pc, 16'h5002);
    idle(6, 1'b1, 1'b1);

    // Reset in FLUSH cycle 1, then reset during LINK
    step(1'b1, OP_JAL, 11'h008, 16'h0, 16'h6000, 1'b0, 1'b0);
    step(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    do_reset();
    idle(5, 1'b1, 1'b1);
    step(1'b1, OP_JALR, 11'h004, 16'h7000, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 5'd0, 11'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    do_reset();
    idle(5, 1'b1, 1'b1);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rv   = ($urandom_range(0, 9) < 7);
      op   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : {3'b001, 2'($urandom)};
      rack = 1'($urandom);
      lack = 1'($urandom);
      step(rv, op, 11'($urandom), 16'($urandom), 16'($urandom), rack, lack);
    end
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
